// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between the CPU data port
// and the screen fetch engine. The CPU has priority. A starvation limit forces one
// screen slot after MAX_CPU_STREAK consecutive CPU slots while a burst is pending.
//
// Optional feature macro: ARB_STATS_EN adds the saturating counters cpu_stall_cnt
// and scr_burst_cnt. Arbitration is identical with or without the macro.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   cpu_req/we/addr/wdata   CPU request (held until cpu_gnt)
//   cpu_gnt           combinational grant: the access issues to RAM this cycle
//   cpu_rvalid/rdata  CPU read return, one cycle after a read grant
//   scr_req/addr      screen burst request and base address
//   scr_busy          burst in progress
//   scr_rvalid/rdata/rindex/done  screen burst word return
//   mem_addr/we/wdata/rdata       RAM interface (address and controls combinational)
//   cpu_stall_cnt, scr_burst_cnt  statistics (ARB_STATS_EN only)
module ram_arbiter #(
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned ADDR_WIDTH     = 12,
   parameter int unsigned BURST_LEN      = 4,
   parameter int unsigned MAX_CPU_STREAK = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          cpu_req,
   input  logic                          cpu_we,
   input  logic [ADDR_WIDTH-1:0]         cpu_addr,
   input  logic [DATA_WIDTH-1:0]         cpu_wdata,
   output logic                          cpu_gnt,
   output logic                          cpu_rvalid,
   output logic [DATA_WIDTH-1:0]         cpu_rdata,
   input  logic                          scr_req,
   input  logic [ADDR_WIDTH-1:0]         scr_addr,
   output logic                          scr_busy,
   output logic                          scr_rvalid,
   output logic [DATA_WIDTH-1:0]         scr_rdata,
   output logic [$clog2(BURST_LEN)-1:0]  scr_rindex,
   output logic                          scr_done,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   output logic                          mem_we,
   output logic [DATA_WIDTH-1:0]         mem_wdata,
   input  logic [DATA_WIDTH-1:0]         mem_rdata
`ifdef ARB_STATS_EN
   ,
   output logic [31:0]                   cpu_stall_cnt,
   output logic [15:0]                   scr_burst_cnt
`endif
);

   localparam int unsigned IDX_W    = $clog2(BURST_LEN);
   localparam int unsigned STREAK_W = $clog2(MAX_CPU_STREAK + 1);
   localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(BURST_LEN - 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_CPU_STREAK);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] base, base_nxt;
   logic [IDX_W-1:0]      idx, idx_nxt;
   logic [STREAK_W-1:0]   streak, streak_nxt;
   logic                  cpu_slot;
   logic                  scr_slot;
   logic                  last_word;

   // Read data is shared; the rvalid strobes tell the owners apart.
   assign cpu_rdata = mem_rdata;
   assign scr_rdata = mem_rdata;
   assign mem_wdata = cpu_wdata;
   assign scr_busy  = (state == BURST);

   // Slot decision, burst bookkeeping and RAM address/control.
   always_comb begin
      state_nxt  = state;
      base_nxt   = base;
      idx_nxt    = idx;
      streak_nxt = streak;
      cpu_slot   = 1'b0;
      scr_slot   = 1'b0;
      last_word  = 1'b0;
      cpu_gnt    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = cpu_addr;

      if (!reset) begin
         if (cpu_req && !(state == BURST && streak == STREAK_MAX)) begin
            cpu_slot = 1'b1;
            cpu_gnt  = 1'b1;
            mem_we   = cpu_we;
            if (state == BURST) begin
               streak_nxt = streak + STREAK_W'(1);
            end
         end else if (state == BURST) begin
            scr_slot   = 1'b1;
            mem_addr   = base + ADDR_WIDTH'(idx);
            streak_nxt = '0;
            if (idx == IDX_LAST) begin
               state_nxt = IDLE;
               last_word = 1'b1;
            end else begin
               idx_nxt = idx + IDX_W'(1);
            end
         end

         // Acceptance only from IDLE; the first screen word issues next cycle.
         if (state == IDLE && scr_req) begin
            base_nxt   = scr_addr;
            idx_nxt    = '0;
            streak_nxt = '0;
            state_nxt  = BURST;
         end
      end
   end

   // State and read-return registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         base       <= '0;
         idx        <= '0;
         streak     <= '0;
         cpu_rvalid <= 1'b0;
         scr_rvalid <= 1'b0;
         scr_done   <= 1'b0;
         scr_rindex <= '0;
      end else begin
         state      <= state_nxt;
         base       <= base_nxt;
         idx        <= idx_nxt;
         streak     <= streak_nxt;
         cpu_rvalid <= cpu_slot && !cpu_we;
         scr_rvalid <= scr_slot;
         scr_done   <= last_word;
         scr_rindex <= idx;
      end
   end

`ifdef ARB_STATS_EN
   // Saturating statistics counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_stall_cnt <= '0;
         scr_burst_cnt <= '0;
      end else begin
         if (cpu_req && !cpu_gnt && (cpu_stall_cnt != '1)) begin
            cpu_stall_cnt <= cpu_stall_cnt + 32'd1;
         end
         if (scr_done && (scr_burst_cnt != '1)) begin
            scr_burst_cnt <= scr_burst_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural one-cycle-latency RAM.
// Unwritten RAM words read back as 16'h5A00 ^ address.
module tb_ram_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req;
   logic        cpu_we;
   logic [11:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic        cpu_gnt;
   logic        cpu_rvalid;
   logic [15:0] cpu_rdata;
   logic        scr_req;
   logic [11:0] scr_addr;
   logic        scr_busy;
   logic        scr_rvalid;
   logic [15:0] scr_rdata;
   logic [1:0]  scr_rindex;
   logic        scr_done;
   logic [11:0] mem_addr;
   logic        mem_we;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
`ifdef ARB_STATS_EN
   logic [31:0] cpu_stall_cnt;
   logic [15:0] scr_burst_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   ram_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .scr_req    (scr_req),
      .scr_addr   (scr_addr),
      .scr_busy   (scr_busy),
      .scr_rvalid (scr_rvalid),
      .scr_rdata  (scr_rdata),
      .scr_rindex (scr_rindex),
      .scr_done   (scr_done),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
`ifdef ARB_STATS_EN
      ,
      .cpu_stall_cnt (cpu_stall_cnt),
      .scr_burst_cnt (scr_burst_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] exp_word(input logic [11:0] a);
      return 16'h5A00 ^ {4'h0, a};
   endfunction

   // Behavioural single-port RAM: synchronous write, registered read.
   logic [15:0] ram     [0:4095];
   logic        written [0:4095];
   always @(posedge clk) begin
      if (mem_we) begin
         ram[mem_addr]     <= mem_wdata;
         written[mem_addr] <= 1'b1;
      end
      mem_rdata <= (written[mem_addr] === 1'b1) ? ram[mem_addr] : exp_word(mem_addr);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; registered outputs are then stable.
   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   // Accept a burst at base b with no CPU traffic and check the whole return.
   task automatic run_burst(input logic [11:0] b);
      cpu_req  = 1'b0;
      scr_req  = 1'b1;
      scr_addr = b;
      #1;
      chk("burst_busy_accept", 32'(scr_busy), 32'd0);
      adv();
      scr_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("burst_busy", 32'(scr_busy), 32'd1);
         chk("burst_mem_addr", 32'(mem_addr), 32'(12'(b + 12'(i))));
         chk("burst_mem_we", 32'(mem_we), 32'd0);
         chk("burst_gnt", 32'(cpu_gnt), 32'd0);
         adv();
         chk("burst_rvalid", 32'(scr_rvalid), 32'd1);
         chk("burst_rindex", 32'(scr_rindex), 32'(i));
         chk("burst_rdata", 32'(scr_rdata), 32'(exp_word(12'(b + 12'(i)))));
         chk("burst_done", 32'(scr_done), 32'(i == 3));
      end
      #1;
      chk("burst_busy_end", 32'(scr_busy), 32'd0);
      adv();
      chk("burst_rvalid_end", 32'(scr_rvalid), 32'd0);
      chk("burst_done_end", 32'(scr_done), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = 12'h010;
      cpu_wdata = 16'h1234;
      scr_req   = 1'b0;
      scr_addr  = 12'h000;

      // Reset: no grant even with a pending CPU write.
      adv();
      #1;
      chk("rst_gnt", 32'(cpu_gnt), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_busy", 32'(scr_busy), 32'd0);
      cpu_we = 1'b0;
      adv();
      chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      chk("rst_scr_rvalid", 32'(scr_rvalid), 32'd0);
      chk("rst_scr_done", 32'(scr_done), 32'd0);
      chk("rst_scr_rindex", 32'(scr_rindex), 32'd0);

      // Idle CPU traffic: write then read back.
      reset  = 1'b0;
      cpu_we = 1'b1;
      #1;
      chk("cpu_wr_gnt", 32'(cpu_gnt), 32'd1);
      chk("cpu_wr_mem_we", 32'(mem_we), 32'd1);
      chk("cpu_wr_addr", 32'(mem_addr), 32'h010);
      chk("cpu_wr_data", 32'(mem_wdata), 32'h1234);
      adv();
      chk("cpu_wr_rvalid", 32'(cpu_rvalid), 32'd0);
      cpu_we = 1'b0;
      #1;
      chk("cpu_rd_gnt", 32'(cpu_gnt), 32'd1);
      chk("cpu_rd_mem_we", 32'(mem_we), 32'd0);
      chk("cpu_rd_addr", 32'(mem_addr), 32'h010);
      adv();
      chk("cpu_rd_rvalid", 32'(cpu_rvalid), 32'd1);
      chk("cpu_rd_rdata", 32'(cpu_rdata), 32'h1234);
      chk("cpu_rd_scr_rvalid", 32'(scr_rvalid), 32'd0);
      chk("cpu_rd_busy", 32'(scr_busy), 32'd0);
      cpu_req = 1'b0;
      #1;
      chk("cpu_idle_gnt", 32'(cpu_gnt), 32'd0);
      adv();
      chk("cpu_idle_rvalid", 32'(cpu_rvalid), 32'd0);

      // Isolated burst at 0x100.
      run_burst(12'h100);

      // Starvation limit from a fresh reset.
      reset = 1'b1;
      adv();
      reset = 1'b0;
`ifdef ARB_STATS_EN
      chk("stats_rst_stall", cpu_stall_cnt, 32'd0);
      chk("stats_rst_burst", 32'(scr_burst_cnt), 32'd0);
`endif
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 12'h010;
      scr_req  = 1'b1;
      scr_addr = 12'h200;
      #1;
      chk("starve_accept_gnt", 32'(cpu_gnt), 32'd1);
      adv();
      scr_req = 1'b0;
      for (int c = 1; c <= 36; c++) begin
         #1;
         chk("starve_gnt", 32'(cpu_gnt), 32'((c % 9) != 0));
         if ((c % 9) == 0) begin
            chk("starve_scr_addr", 32'(mem_addr), 32'h200 + 32'((c / 9) - 1));
         end
         adv();
         chk("starve_scr_rvalid", 32'(scr_rvalid), 32'((c % 9) == 0));
         chk("starve_done", 32'(scr_done), 32'(c == 36));
      end
      cpu_req = 1'b0;
      #1;
      chk("starve_busy_end", 32'(scr_busy), 32'd0);
      adv();
`ifdef ARB_STATS_EN
      chk("stats_stall", cpu_stall_cnt, 32'd4);
      chk("stats_burst", 32'(scr_burst_cnt), 32'd1);
`endif

      // Address wrap.
      run_burst(12'hFFE);

      // scr_req during BURST is ignored; reset abandons the burst.
      scr_req  = 1'b1;
      scr_addr = 12'h100;
      adv();
      scr_addr = 12'h200;
      #1;
      chk("ign_addr0", 32'(mem_addr), 32'h100);
      adv();
      chk("ign_rindex0", 32'(scr_rindex), 32'd0);
      #1;
      chk("ign_addr1", 32'(mem_addr), 32'h101);
      chk("ign_busy", 32'(scr_busy), 32'd1);
      adv();
      chk("ign_rvalid1", 32'(scr_rvalid), 32'd1);
      chk("ign_rindex1", 32'(scr_rindex), 32'd1);
      reset   = 1'b1;
      scr_req = 1'b0;
      #1;
      chk("abort_gnt", 32'(cpu_gnt), 32'd0);
      chk("abort_mem_we", 32'(mem_we), 32'd0);
      adv();
      chk("abort_busy", 32'(scr_busy), 32'd0);
      chk("abort_rvalid", 32'(scr_rvalid), 32'd0);
      chk("abort_done", 32'(scr_done), 32'd0);
      reset = 1'b0;
      adv();
      chk("post_abort_rvalid", 32'(scr_rvalid), 32'd0);
      chk("post_abort_done", 32'(scr_done), 32'd0);
      chk("post_abort_busy", 32'(scr_busy), 32'd0);
      run_burst(12'h100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one single-port synchronous data RAM between two requesters: the CPU data port and the screen fetch engine.
- The screen fetch engine requests fixed-length read bursts to refill the video line buffer.
- The CPU has priority. A starvation limit guarantees that a pending screen burst makes progress.
- Sits between cpu/ram-style masters and the RAM instance, in the cpu_clk domain.

Parameters:
- DATA_WIDTH, 16, word width.
- ADDR_WIDTH, 12, RAM address width.
- BURST_LEN, 4, words per screen burst (>=2, power of two).
- MAX_CPU_STREAK, 8, max consecutive CPU slots while a screen burst is pending (>=1).

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; held until granted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_gnt  out  1  combinational; the access issues to RAM this cycle.
- cpu_rvalid  out  1  registered; cpu_rdata valid.
- cpu_rdata  out  DATA_WIDTH  read data (passthrough of mem_rdata).
- scr_req  in  1  burst request pulse/level.
- scr_addr  in  ADDR_WIDTH  burst base address, sampled on acceptance.
- scr_busy  out  1  burst in progress.
- scr_rvalid  out  1  registered; scr_rdata valid.
- scr_rdata  out  DATA_WIDTH  burst word.
- scr_rindex  out  $clog2(BURST_LEN)  word index within the burst, qualified by scr_rvalid.
- scr_done  out  1  one-cycle pulse coincident with the last scr_rvalid.
- mem_addr  out  ADDR_WIDTH  RAM address (combinational).
- mem_we  out  1  RAM write enable (combinational).
- mem_wdata  out  DATA_WIDTH  RAM write data.
- mem_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after the address is issued.

Behaviour:
- States: IDLE, BURST. Registers: base, idx (0..BURST_LEN-1), streak (0..MAX_CPU_STREAK), cpu_rd_pend, scr_rd_pend, last_pend.
- IDLE:
  - scr_req=1 accepts the burst: base<=scr_addr, idx<=0, streak<=0, state<=BURST.
  - No screen word issues in the acceptance cycle.
  - The CPU may be granted in the same cycle.
- Slot decision, evaluated each cycle, exactly one owner or none:
  - cpu_req && !(BURST && streak==MAX_CPU_STREAK) → CPU slot. cpu_gnt=1, mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata. If BURST, streak++.
  - Else if BURST → screen slot. cpu_gnt=0, mem_addr=(base+idx) mod 2^ADDR_WIDTH, mem_we=0. streak<=0.
    - If idx==BURST_LEN-1: state<=IDLE and the last word is marked.
    - Otherwise idx++.
  - Else: no slot. mem_we=0, mem_addr=cpu_addr (don't-care).
- cpu_gnt is never asserted when cpu_req=0. mem_we is 1 only on a CPU write slot.
- Read return: latency 1 cycle.
  - cpu_rvalid<=CPU slot && !cpu_we.
  - scr_rvalid<=screen slot; scr_rindex<=idx registered alongside.
  - scr_done<=screen slot && last word.
  - cpu_rdata = scr_rdata = mem_rdata.
- scr_busy=1 exactly while state==BURST. scr_req is ignored while BURST, including in the cycle the last word issues.
  - A new burst can be accepted in the first IDLE cycle.
- Address wrap: base+idx wraps modulo 2^ADDR_WIDTH. Example: base=0xFFE, BURST_LEN=4 → addresses FFE, FFF, 000, 001.
- Worst-case screen progress: one word per MAX_CPU_STREAK+1 cycles. Full burst ≤ BURST_LEN*(MAX_CPU_STREAK+1) cycles after acceptance+1.
- Reset (synchronous):
  - state=IDLE; idx, streak, base = 0.
  - cpu_rvalid, scr_rvalid, scr_done, scr_rindex = 0.
  - scr_busy=0, cpu_gnt=0, mem_we=0.
  - Reset asserted mid-burst abandons the burst. A read issued in the reset cycle produces no rvalid.
  - While reset=1, no slot is granted.

Optional Feature:
- ARB_STATS_EN: adds output cpu_stall_cnt (32-bit) and output scr_burst_cnt (16-bit).
  - cpu_stall_cnt counts cycles with cpu_req && !cpu_gnt.
  - scr_burst_cnt counts scr_done pulses.
  - Both counters saturate at all-ones and clear on reset.
- Without the macro, both ports and counters are absent. Arbitration behaviour is identical either way.

Test Plan:
- Idle CPU traffic: CPU write 0x1234@0x010, then read @0x010 → cpu_gnt same cycle each; cpu_rvalid one cycle after the read with cpu_rdata=0x1234; scr_* stay 0.
- Isolated burst: scr_req with scr_addr=0x100, RAM[0x100..0x103]=A,B,C,D, no CPU traffic → mem_addr 100..103 on cycles 1..4 after acceptance; scr_rvalid cycles 2..5 with rindex 0..3 and data A..D; scr_done on rindex 3; scr_busy high cycles 1..4.
- Starvation limit (MAX_CPU_STREAK=8): burst accepted while cpu_req held continuously → pattern of 8 CPU grants, 1 screen slot (cpu_gnt=0), repeated; burst completes in 36 cycles.
- Wrap: scr_addr=0xFFE → mem_addr sequence FFE, FFF, 000, 001.
- Ignored request plus reset: scr_req asserted during BURST → no rebase. Reset asserted after 2 words issued → scr_busy=0 and no further scr_rvalid/scr_done; the next scr_req after reset is accepted normally.
- ARB_STATS_EN: the starvation scenario gives cpu_stall_cnt=4 and scr_burst_cnt=1.
